imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 Parameter SLTIU_ZEXT, default 1; 1 = OP-IMM funct3 011 immediate zero-extended, 0 = sign-extended.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous discard of all held entries.
REQ-006 in_valid  input  1  in_instr carries an instruction.
REQ-007 in_instr  input  32  raw RV32 instruction word.
REQ-008 in_ready  output  1  block accepts in_instr this cycle.
REQ-009 out_valid  output  1  out_* fields valid.
REQ-010 out_ready  input  1  consumer accepts the output this cycle.
REQ-011 out_imm  output  XLEN  extended immediate.
REQ-012 out_fmt  output  3  format: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 shamt, 7 CSR zimm.
REQ-013 out_illegal  output  1  opcode not in the REQ-016 table.

Function
REQ-014 Input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-015 Latency: an instruction accepted in cycle N appears on out_* in cycle N+1 when the output register is empty or drains in cycle N.
REQ-016 Decode by opcode in_instr[6:0]: 0000011, 1100111 -> I; 0010011 -> I except funct3 001/101 -> shamt; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; 1110011 -> CSR zimm; any other -> fmt 0, imm 0, illegal 1.
REQ-017 I: sign-extend instr[31:20].
REQ-018 OP-IMM funct3 011: zero-extend instr[31:20] when SLTIU_ZEXT=1, else sign-extend.
REQ-019 shamt: zero-extend instr[24:20] when XLEN=32, instr[25:20] when XLEN=64; funct7 bits never appear in out_imm.
REQ-020 S: sign-extend {instr[31:25], instr[11:7]}.
REQ-021 B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
REQ-022 U: {instr[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64.
REQ-023 J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
REQ-024 CSR zimm: zero-extend instr[19:15].
REQ-025 Storage: one output register plus one skid register; capacity 2 entries; no combinational path from out_ready to in_ready.
REQ-026 in_ready is registered and equals !skid_full.
REQ-027 Output register full and not drained while a transfer is accepted: the decoded entry goes to the skid register.
REQ-028 Output register drains while skid is full: skid moves to the output register in the same edge; skid becomes empty.
REQ-029 Simultaneous drain and accept with skid empty: the new entry loads the output register directly.
REQ-030 Entries leave in acceptance order; none is dropped or duplicated.
REQ-031 flush: next edge clears out_valid and skid_full, sets in_ready 1; an input presented in a flush cycle is discarded; flush has priority over all transfers.
REQ-032 out_imm, out_fmt and out_illegal hold stable while out_valid && !out_ready.
REQ-033 rst asserted mid-transfer: all entries lost, no partial output.

Reset
REQ-034 On rst: out_valid 0, out_imm 0, out_fmt 0, out_illegal 0, skid register empty, in_ready 1.
REQ-035 First acceptance is possible in the first cycle after rst deasserts.

Verification
REQ-036 Push 0xFFF00093 (addi x1,x0,-1) with out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1.
REQ-037 Push 0xFE112E23 (sw x1,-4(x2)) -> out_imm=0xFFFFFFFC, fmt 2; push 0x123450B7 (lui) -> out_imm=0x12345000, fmt 4.
REQ-038 Push 0xFFF03093 (sltiu, imm 0xFFF) -> 0x00000FFF with SLTIU_ZEXT=1, 0xFFFFFFFF with 0; push 0x4030D093 (srai 3) -> out_imm=3, fmt 6.
REQ-039 out_ready=0, push A, B back-to-back -> in_ready 0 after B; hold 3 cycles, A stable; raise out_ready -> A then B on consecutive cycles, in_ready 1 again.
REQ-040 Two entries held, assert flush while in_valid=1 -> next cycle out_valid=0, in_ready=1; flush-cycle input never appears.
REQ-041 Push 0x0000007F -> out_illegal=1, fmt 0, imm 0; assert rst with a held entry -> all outputs 0 immediately, in_ready 1.

Source files
------------

// File: rtl/imm_gen_if.sv
// Handshake and result bus for the pipelined RV32 immediate generator.
// The master side presents instructions and consumes decoded immediates;
// the slave side is the immediate generator itself.
interface imm_gen_if #(
  parameter int XLEN = 32
);

  logic            flush;
  logic            in_valid;
  logic [31:0]     in_instr;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output flush,
    output in_valid,
    output in_instr,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_imm,
    input  out_fmt,
    input  out_illegal
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  in_instr,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_imm,
    output out_fmt,
    output out_illegal
  );

endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32 immediate generator.
// Decodes the immediate field of a raw instruction word, extends it to XLEN
// bits and delivers it through a two-entry elastic buffer (output register
// plus skid register). in_ready depends only on the skid flop, so there is
// no combinational path from out_ready back to in_ready.
module imm_gen_pipe #(
  parameter int XLEN       = 32,
  parameter int SLTIU_ZEXT = 1
) (
  input  logic   clk,
  input  logic   rst,
  imm_gen_if.slave bus
);

  // Immediate format codes presented on out_fmt.
  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_ZIMM  = 3'd7;

  // Major opcodes that carry an immediate.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // OP-IMM funct3 values that need special immediate handling.
  localparam logic [2:0] F3_SLL   = 3'b001;
  localparam logic [2:0] F3_SRX   = 3'b101;
  localparam logic [2:0] F3_SLTIU = 3'b011;

  // One buffered decode result.
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  entry_t     dec;
  entry_t     out_q;
  entry_t     skid_q;
  logic       out_valid_q;
  logic       skid_full_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       in_ready;
  logic       accept;
  logic       drain;
  logic       out_free;
  logic       load_skid;

  assign opcode = bus.in_instr[6:0];
  assign funct3 = bus.in_instr[14:12];

  // Decode the incoming instruction word into an extended immediate and format.
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // field unassigned, which would otherwise infer a latch.
    dec.imm     = '0;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    unique case (opcode)
      OP_LOAD, OP_JALR: begin
        dec.fmt = FMT_I;
        dec.imm = XLEN'($signed(bus.in_instr[31:20]));
      end
      OP_IMM: begin
        if (funct3 == F3_SLL || funct3 == F3_SRX) begin
          // Shift amount only; the funct7 bits above it never leak through.
          dec.fmt = FMT_SHAMT;
          if (XLEN == 64) dec.imm = XLEN'(bus.in_instr[25:20]);
          else            dec.imm = XLEN'(bus.in_instr[24:20]);
        end else if (funct3 == F3_SLTIU && SLTIU_ZEXT != 0) begin
          dec.fmt = FMT_I;
          dec.imm = XLEN'(bus.in_instr[31:20]);
        end else begin
          dec.fmt = FMT_I;
          dec.imm = XLEN'($signed(bus.in_instr[31:20]));
        end
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        dec.imm = XLEN'($signed({bus.in_instr[31:25], bus.in_instr[11:7]}));
      end
      OP_BRANCH: begin
        dec.fmt = FMT_B;
        dec.imm = XLEN'($signed({bus.in_instr[31], bus.in_instr[7],
                                 bus.in_instr[30:25], bus.in_instr[11:8], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        // Upper immediate; on RV64 bit 31 is replicated into the upper word.
        dec.fmt = FMT_U;
        dec.imm = XLEN'($signed({bus.in_instr[31:12], 12'b0}));
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        dec.imm = XLEN'($signed({bus.in_instr[31], bus.in_instr[19:12],
                                 bus.in_instr[20], bus.in_instr[30:21], 1'b0}));
      end
      OP_SYSTEM: begin
        // CSR immediate forms use the rs1 field as a 5-bit unsigned value.
        dec.fmt = FMT_ZIMM;
        dec.imm = XLEN'(bus.in_instr[19:15]);
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Handshake terms. A new word is taken only while the skid slot is free;
  // flush discards whatever is presented in the same cycle.
  assign in_ready  = !skid_full_q;
  assign accept    = bus.in_valid && in_ready && !bus.flush;
  assign drain     = out_valid_q && bus.out_ready;
  assign out_free  = !out_valid_q || drain;
  assign load_skid = accept && !out_free;

  // Output register and occupancy flags: refill from skid first, else from input.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
      out_q       <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
    end else if (out_free) begin
      if (skid_full_q) begin
        // Older entry waiting in skid moves forward; input is stalled.
        out_q       <= skid_q;
        out_valid_q <= 1'b1;
        skid_full_q <= 1'b0;
      end else if (accept) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_full_q <= 1'b1;
    end
  end

  // Skid payload capture when the output register is occupied and held.
  always_ff @(posedge clk) begin
    // NOTE: the skid payload has no reset; skid_full_q qualifies it, so its
    // contents are never observed until written.
    if (load_skid) skid_q <= dec;
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_fmt     = out_q.fmt;
  assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe. Three instances share one stimulus
// stream: RV32 with zero-extended SLTIU, RV32 with sign-extended SLTIU, and
// RV64. A queue of accepted instruction words models the buffer contents and
// an arithmetic decoder produces the expected immediates.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;

  int n_cmp;
  int n_bad;

  logic [31:0] mq[$];

  imm_gen_if #(.XLEN(32)) b32  ();
  imm_gen_if #(.XLEN(32)) b32z ();
  imm_gen_if #(.XLEN(64)) b64  ();

  assign b32.flush      = flush;
  assign b32.in_valid   = in_valid;
  assign b32.in_instr   = in_instr;
  assign b32.out_ready  = out_ready;
  assign b32z.flush     = flush;
  assign b32z.in_valid  = in_valid;
  assign b32z.in_instr  = in_instr;
  assign b32z.out_ready = out_ready;
  assign b64.flush      = flush;
  assign b64.in_valid   = in_valid;
  assign b64.in_instr   = in_instr;
  assign b64.out_ready  = out_ready;

  imm_gen_pipe #(.XLEN(32), .SLTIU_ZEXT(1)) dut32  (.clk(clk), .rst(rst), .bus(b32));
  imm_gen_pipe #(.XLEN(32), .SLTIU_ZEXT(0)) dut32z (.clk(clk), .rst(rst), .bus(b32z));
  imm_gen_pipe #(.XLEN(64), .SLTIU_ZEXT(1)) dut64  (.clk(clk), .rst(rst), .bus(b64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic longint sx(input longint v, input int bits);
    if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
    return v;
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] i, input int xlen, input bit zext);
    longint v;
    case (i[6:0])
      7'h03, 7'h67: v = sx(longint'(i[31:20]), 12);
      7'h13: begin
        if (i[14:12] == 3'd1 || i[14:12] == 3'd5)
          v = (xlen == 32) ? longint'(i[24:20]) : longint'(i[25:20]);
        else if (i[14:12] == 3'd3 && zext)
          v = longint'(i[31:20]);
        else
          v = sx(longint'(i[31:20]), 12);
      end
      7'h23: v = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
      7'h63: v = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048
                    + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
      7'h37, 7'h17: v = sx(longint'(i[31:12]) * 4096, 32);
      7'h6F: v = sx(longint'(i[31]) * (1 << 20) + longint'(i[19:12]) * 4096
                    + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
      7'h73: v = longint'(i[19:15]);
      default: v = 0;
    endcase
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  function automatic logic [2:0] ref_fmt(input logic [31:0] i);
    case (i[6:0])
      7'h03, 7'h67: return 3'd1;
      7'h13:        return (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? 3'd6 : 3'd1;
      7'h23:        return 3'd2;
      7'h63:        return 3'd3;
      7'h37, 7'h17: return 3'd4;
      7'h6F:        return 3'd5;
      7'h73:        return 3'd7;
      default:      return 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0:  r[6:0] = 7'h03;
      1:  r[6:0] = 7'h67;
      2,
      3,
      4:  r[6:0] = 7'h13;
      5:  r[6:0] = 7'h23;
      6:  r[6:0] = 7'h63;
      7:  r[6:0] = 7'h37;
      8:  r[6:0] = 7'h17;
      9:  r[6:0] = 7'h6F;
      10: r[6:0] = 7'h73;
      default: ;
    endcase
    return r;
  endfunction

  // Advance one clock and update the model with the transfers that edge makes.
  task automatic tick();
    bit acc;
    bit drn;
    acc = in_valid && (mq.size() < 2) && !flush;
    drn = (mq.size() > 0) && out_ready;
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(in_instr);
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", b32.out_valid); end
    n_cmp++; if (b32.out_imm !== 32'h0) begin n_bad++; $display("FAIL reset_out_imm: got %h want 0", b32.out_imm); end
    n_cmp++; if (b32.out_fmt !== 3'd0) begin n_bad++; $display("FAIL reset_out_fmt: got %0d want 0", b32.out_fmt); end
    n_cmp++; if (b32.out_illegal !== 1'b0) begin n_bad++; $display("FAIL reset_out_illegal: got %b want 0", b32.out_illegal); end
    n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", b32.in_ready); end
    n_cmp++; if (b64.out_imm !== 64'h0) begin n_bad++; $display("FAIL reset_out_imm64: got %h want 0", b64.out_imm); end
    rst = 1'b0;
    mq.delete();
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] e32;
    logic [31:0] e32z;
    logic [63:0] e64;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  task automatic test_decode();
    vec_t v[7];
    v[0] = '{32'hFFF00093, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0};
    v[1] = '{32'hFE112E23, 32'hFFFFFFFC, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0};
    v[2] = '{32'h123450B7, 32'h12345000, 32'h12345000, 64'h00000000_12345000, 3'd4, 1'b0};
    v[3] = '{32'hFFF03093, 32'h00000FFF, 32'hFFFFFFFF, 64'h00000000_00000FFF, 3'd1, 1'b0};
    v[4] = '{32'h4030D093, 32'h00000003, 32'h00000003, 64'h00000000_00000003, 3'd6, 1'b0};
    v[5] = '{32'h03F09093, 32'h0000001F, 32'h0000001F, 64'h00000000_0000003F, 3'd6, 1'b0};
    v[6] = '{32'h0000007F, 32'h00000000, 32'h00000000, 64'h00000000_00000000, 3'd0, 1'b1};
    out_ready = 1'b1;
    // First push lands in the first cycle after reset release.
    n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL first_in_ready: got %b want 1", b32.in_ready); end
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_instr = v[k].instr;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (b32.out_valid !== 1'b1) begin n_bad++; $display("FAIL decode%0d_valid: got %b want 1", k, b32.out_valid); end
      n_cmp++; if (b32.out_imm !== v[k].e32) begin n_bad++; $display("FAIL decode%0d_imm32: got %h want %h", k, b32.out_imm, v[k].e32); end
      n_cmp++; if (b32z.out_imm !== v[k].e32z) begin n_bad++; $display("FAIL decode%0d_imm32z: got %h want %h", k, b32z.out_imm, v[k].e32z); end
      n_cmp++; if (b64.out_imm !== v[k].e64) begin n_bad++; $display("FAIL decode%0d_imm64: got %h want %h", k, b64.out_imm, v[k].e64); end
      n_cmp++; if (b32.out_fmt !== v[k].fmt) begin n_bad++; $display("FAIL decode%0d_fmt: got %0d want %0d", k, b32.out_fmt, v[k].fmt); end
      n_cmp++; if (b32.out_illegal !== v[k].ill) begin n_bad++; $display("FAIL decode%0d_illegal: got %b want %b", k, b32.out_illegal, v[k].ill); end
      tick();
      n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL decode%0d_drained: got %b want 0", k, b32.out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00500093;
    tick();
    in_instr  = 32'h80000537;
    tick();
    in_valid  = 1'b0;
    n_cmp++; if (b32.in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full_in_ready: got %b want 0", b32.in_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (b32.out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_hold%0d_valid: got %b want 1", k, b32.out_valid); end
      n_cmp++; if (b32.out_imm !== 32'h5) begin n_bad++; $display("FAIL b2b_hold%0d_imm: got %h want 5", k, b32.out_imm); end
      n_cmp++; if (b32.out_fmt !== 3'd1) begin n_bad++; $display("FAIL b2b_hold%0d_fmt: got %0d want 1", k, b32.out_fmt); end
    end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (b32.out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_second_valid: got %b want 1", b32.out_valid); end
    n_cmp++; if (b32.out_imm !== 32'h80000000) begin n_bad++; $display("FAIL b2b_second_imm: got %h want 80000000", b32.out_imm); end
    n_cmp++; if (b64.out_imm !== 64'hFFFFFFFF_80000000) begin n_bad++; $display("FAIL b2b_second_imm64: got %h want ffffffff80000000", b64.out_imm); end
    n_cmp++; if (b32.out_fmt !== 3'd4) begin n_bad++; $display("FAIL b2b_second_fmt: got %0d want 4", b32.out_fmt); end
    n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_again: got %b want 1", b32.in_ready); end
    tick();
    n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty: got %b want 0", b32.out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00500093;
    tick();
    in_instr  = 32'h80000537;
    tick();
    flush     = 1'b1;
    in_instr  = 32'h7FF00093;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %b want 0", b32.out_valid); end
    n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready: got %b want 1", b32.in_ready); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_ghost%0d: got %b want 0", k, b32.out_valid); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00093;
    tick();
    in_instr  = 32'h0000007F;
    tick();
    in_valid  = 1'b0;
    n_cmp++; if (b32.out_imm !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL rstmid_pre_imm: got %h want ffffffff", b32.out_imm); end
    rst = 1'b1;
    #1;
    n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", b32.out_valid); end
    n_cmp++; if (b32.out_imm !== 32'h0) begin n_bad++; $display("FAIL rstmid_imm: got %h want 0", b32.out_imm); end
    n_cmp++; if (b32.out_fmt !== 3'd0) begin n_bad++; $display("FAIL rstmid_fmt: got %0d want 0", b32.out_fmt); end
    n_cmp++; if (b32.out_illegal !== 1'b0) begin n_bad++; $display("FAIL rstmid_illegal: got %b want 0", b32.out_illegal); end
    n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready: got %b want 1", b32.in_ready); end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_after: got %b want 0", b32.out_valid); end
  endtask

  task automatic test_random();
    logic [31:0] f;
    bit          ev;
    bit          er;
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
      ev = (mq.size() > 0);
      er = (mq.size() < 2);
      n_cmp++; if (b32.out_valid !== ev) begin n_bad++; $display("FAIL rand%0d_valid32: got %b want %b", c, b32.out_valid, ev); end
      n_cmp++; if (b64.out_valid !== ev) begin n_bad++; $display("FAIL rand%0d_valid64: got %b want %b", c, b64.out_valid, ev); end
      n_cmp++; if (b32.in_ready !== er) begin n_bad++; $display("FAIL rand%0d_ready32: got %b want %b", c, b32.in_ready, er); end
      n_cmp++; if (b32z.in_ready !== er) begin n_bad++; $display("FAIL rand%0d_ready32z: got %b want %b", c, b32z.in_ready, er); end
      if (ev) begin
        f = mq[0];
        n_cmp++; if (b32.out_imm !== ref_imm(f, 32, 1'b1)) begin n_bad++; $display("FAIL rand%0d_imm32 instr %h: got %h want %h", c, f, b32.out_imm, ref_imm(f, 32, 1'b1)); end
        n_cmp++; if (b32z.out_imm !== ref_imm(f, 32, 1'b0)) begin n_bad++; $display("FAIL rand%0d_imm32z instr %h: got %h want %h", c, f, b32z.out_imm, ref_imm(f, 32, 1'b0)); end
        n_cmp++; if (b64.out_imm !== ref_imm(f, 64, 1'b1)) begin n_bad++; $display("FAIL rand%0d_imm64 instr %h: got %h want %h", c, f, b64.out_imm, ref_imm(f, 64, 1'b1)); end
        n_cmp++; if (b32.out_fmt !== ref_fmt(f)) begin n_bad++; $display("FAIL rand%0d_fmt instr %h: got %0d want %0d", c, f, b32.out_fmt, ref_fmt(f)); end
        n_cmp++; if (b32.out_illegal !== (ref_fmt(f) == 3'd0)) begin n_bad++; $display("FAIL rand%0d_illegal instr %h: got %b want %b", c, f, b32.out_illegal, (ref_fmt(f) == 3'd0)); end
      end
    end
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
